// File: rtl/st_commit_unit_pkg.sv
// Shared tag constants and commit FSM encoding for the store commit path.
package st_commit_unit_pkg;

  localparam int TAG_W = 4;

  localparam logic [TAG_W-1:0] NOTAG  = 4'd0;
  localparam logic [TAG_W-1:0] ADD_1  = 4'd1;
  localparam logic [TAG_W-1:0] ADD_2  = 4'd2;
  localparam logic [TAG_W-1:0] ADD_3  = 4'd3;
  localparam logic [TAG_W-1:0] MULT_1 = 4'd4;
  localparam logic [TAG_W-1:0] MULT_2 = 4'd5;
  localparam logic [TAG_W-1:0] LD_1   = 4'd6;
  localparam logic [TAG_W-1:0] LD_2   = 4'd7;
  localparam logic [TAG_W-1:0] LD_3   = 4'd8;
  localparam logic [TAG_W-1:0] ST_1   = 4'd9;
  localparam logic [TAG_W-1:0] ST_2   = 4'd10;

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_REQ  = 2'd1,
    S_REL  = 2'd2
  } commit_state_t;

endpackage

// File: rtl/st_commit_unit_if.sv
// Data-memory write port: request/ack handshake carrying one store.
interface st_commit_unit_if #(
  parameter int ADDR_W = 64,
  parameter int DATA_W = 64
);
  logic              mem_req;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_ack;

  modport master (output mem_req, mem_addr, mem_wdata, input mem_ack);
  modport slave  (input mem_req, mem_addr, mem_wdata, output mem_ack);
endinterface

// File: rtl/st_commit_unit_order_fifo.sv
// Two-entry FIFO of store entry indices, kept in allocation (program) order.
module st_order_fifo (
  input  logic       clk,
  input  logic       rst_n,
  input  logic       push,
  input  logic       push_idx,
  input  logic       pop,
  output logic       head,
  output logic [1:0] count
);

  logic [1:0] slot;
  logic       rd_ptr;
  logic       wr_ptr;
  logic       do_push;
  logic       do_pop;

  assign do_pop  = pop && (count != 2'd0);
  // A full queue still takes a push when the head leaves in the same cycle.
  assign do_push = push && ((count != 2'd2) || do_pop);
  assign head    = slot[rd_ptr];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      slot   <= 2'b00;
      rd_ptr <= 1'b0;
      wr_ptr <= 1'b0;
      count  <= 2'd0;
    end else begin
      if (do_push) begin
        slot[wr_ptr] <= push_idx;
        wr_ptr       <= ~wr_ptr;
      end
      if (do_pop) rd_ptr <= ~rd_ptr;
      count <= count + {1'b0, do_push} - {1'b0, do_pop};
    end
  end

  overflow_chk: assert property (@(posedge clk) disable iff (!rst_n)
    !(push && (count == 2'd2) && !do_pop));

endmodule

// File: rtl/st_commit_unit.sv
// Commits the oldest resolved store from the 2-entry store RS to data memory.
//   state | meaning
//   IDLE  | waiting for the queue head to have operands and address
//   REQ   | write request held with latched addr/data until mem_ack
//   REL   | one-cycle tag release to the RS, head popped
module st_commit_unit
  import st_commit_unit_pkg::*;
#(
  parameter int              ADDR_W  = 64,
  parameter int              DATA_W  = 64,
  parameter logic [TAG_W-1:0] TAG_ST1 = ST_1,
  parameter logic [TAG_W-1:0] TAG_ST2 = ST_2
) (
  input  logic                  clk,
  input  logic                  rst_n,
  input  logic                  alloc_valid,
  input  logic [TAG_W-1:0]      alloc_tag,
  input  logic [1:0]            rs_ready_bus,
  input  logic [1:0]            addr_done,
  input  logic [2*ADDR_W-1:0]   rs_st_addr,
  input  logic [2*DATA_W-1:0]   rs_st_data,
  st_commit_unit_if.master      mem,
  output logic                  free_tag_flag,
  output logic [TAG_W-1:0]      free_this_tag,
  output logic                  busy
);

  commit_state_t     state;
  commit_state_t     state_nxt;
  logic              head;
  logic [1:0]        q_count;
  logic [1:0]        addr_ok;
  logic [1:0]        rel_mask;
  logic              cand;
  logic              push;
  logic              push_idx;
  logic              pop;
  logic [ADDR_W-1:0] addr_q;
  logic [DATA_W-1:0] wdata_q;

  assign push     = alloc_valid && ((alloc_tag == TAG_ST1) || (alloc_tag == TAG_ST2));
  assign push_idx = (alloc_tag == TAG_ST2);
  assign pop      = (state == S_REL);
  assign rel_mask = pop ? (head ? 2'b10 : 2'b01) : 2'b00;

  st_order_fifo u_order (
    .clk      (clk),
    .rst_n    (rst_n),
    .push     (push),
    .push_idx (push_idx),
    .pop      (pop),
    .head     (head),
    .count    (q_count)
  );

  // rs_ready_bus is packed opposite to the entry index: bit1 is entry0.
  assign cand = (q_count != 2'd0) && rs_ready_bus[~head] && addr_ok[head];

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) addr_ok <= 2'b00;
    else        addr_ok <= (addr_ok | addr_done) & ~rel_mask;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) state <= S_IDLE;
    else        state <= state_nxt;
  end

  always_comb begin
    state_nxt = state;
    case (state)
      S_IDLE:  if (cand) state_nxt = S_REQ;
      S_REQ:   if (mem.mem_ack) state_nxt = S_REL;
      S_REL:   state_nxt = S_IDLE;
      default: state_nxt = S_IDLE;
    endcase
  end

  // Snapshot at issue so RS updates cannot disturb an in-flight write.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      addr_q  <= '0;
      wdata_q <= '0;
    end else if ((state == S_IDLE) && cand) begin
      addr_q  <= head ? rs_st_addr[2*ADDR_W-1:ADDR_W] : rs_st_addr[ADDR_W-1:0];
      wdata_q <= head ? rs_st_data[2*DATA_W-1:DATA_W] : rs_st_data[DATA_W-1:0];
    end
  end

  assign mem.mem_req   = (state == S_REQ);
  assign mem.mem_addr  = addr_q;
  assign mem.mem_wdata = wdata_q;
  assign free_tag_flag = (state == S_REL);
  assign free_this_tag = free_tag_flag ? (head ? TAG_ST2 : TAG_ST1) : NOTAG;
  assign busy          = (state != S_IDLE);

endmodule

// File: tb/tb_st_commit_unit.sv
// Directed bench for st_commit_unit with a transaction-level program-order model.
module tb_st_commit_unit;
  import st_commit_unit_pkg::*;

  localparam int AW = 64;
  localparam int DW = 64;

  logic            clk = 1'b0;
  logic            rst_n = 1'b0;
  logic            alloc_valid = 1'b0;
  logic [3:0]      alloc_tag = 4'd0;
  logic [1:0]      rs_ready_bus = 2'b00;
  logic [1:0]      addr_done = 2'b00;
  logic [2*AW-1:0] rs_st_addr = '0;
  logic [2*DW-1:0] rs_st_data = '0;
  logic            free_tag_flag;
  logic [3:0]      free_this_tag;
  logic            busy;

  int n_checks = 0;
  int n_fail = 0;

  st_commit_unit_if #(.ADDR_W(AW), .DATA_W(DW)) mem_bus ();

  st_commit_unit #(.ADDR_W(AW), .DATA_W(DW), .TAG_ST1(ST_1), .TAG_ST2(ST_2)) dut (
    .clk           (clk),
    .rst_n         (rst_n),
    .alloc_valid   (alloc_valid),
    .alloc_tag     (alloc_tag),
    .rs_ready_bus  (rs_ready_bus),
    .addr_done     (addr_done),
    .rs_st_addr    (rs_st_addr),
    .rs_st_data    (rs_st_data),
    .mem           (mem_bus),
    .free_tag_flag (free_tag_flag),
    .free_this_tag (free_this_tag),
    .busy          (busy)
  );

  always #5 clk = ~clk;

  task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got 0x%0h expected 0x%0h", name, act, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic set_entry(input int e, input logic [63:0] a, input logic [63:0] d);
    if (e == 0) begin
      rs_st_addr[63:0] = a;
      rs_st_data[63:0] = d;
    end else begin
      rs_st_addr[127:64] = a;
      rs_st_data[127:64] = d;
    end
  endtask

  task automatic do_reset();
    rst_n = 1'b0;
    alloc_valid = 1'b0;
    addr_done = 2'b00;
    rs_ready_bus = 2'b00;
    mem_bus.mem_ack = 1'b0;
    repeat (2) tick();
    rst_n = 1'b1;
    tick();
  endtask

  task automatic wait_req(input string nm);
    int t;
    t = 0;
    while (!mem_bus.mem_req && t < 30) begin
      tick();
      t++;
    end
    check({nm, "_req_seen"}, 64'(mem_bus.mem_req), 64'd1);
  endtask

  task automatic commit(input string nm, input logic [3:0] tag, input logic [63:0] a,
                        input logic [63:0] d, input int hold);
    wait_req(nm);
    if (mem_bus.mem_req) begin
      check({nm, "_addr"}, mem_bus.mem_addr, a);
      check({nm, "_data"}, mem_bus.mem_wdata, d);
      repeat (hold) begin
        tick();
        check({nm, "_hold"}, 64'(mem_bus.mem_req), 64'd1);
      end
      mem_bus.mem_ack = 1'b1;
      tick();
      mem_bus.mem_ack = 1'b0;
      check({nm, "_flag"}, 64'(free_tag_flag), 64'd1);
      check({nm, "_tag"}, 64'(free_this_tag), 64'(tag));
      tick();
      check({nm, "_flag_end"}, 64'(free_tag_flag), 64'd0);
    end
  endtask

  // Model: entries commit strictly in allocation order once ready and addressed.
  int unsigned mq[$];
  logic [1:0]  ok_m = 2'b00;
  logic        prev_req = 1'b0, prev_flag = 1'b0, prev_cand = 1'b0, prev_busy = 1'b0;
  logic [63:0] prev_head_addr = '0, prev_head_data = '0, prev_mem_addr = '0, prev_mem_wdata = '0;

  always @(negedge clk) begin
    int h;
    logic cand_now;
    logic [63:0] exp_tag;
    if (!rst_n) begin
      check("rst_req", 64'(mem_bus.mem_req), 64'd0);
      check("rst_flag", 64'(free_tag_flag), 64'd0);
      check("rst_tag", 64'(free_this_tag), 64'd0);
      check("rst_busy", 64'(busy), 64'd0);
      mq.delete();
      ok_m = 2'b00;
      prev_req = 1'b0;
      prev_flag = 1'b0;
      prev_cand = 1'b0;
      prev_busy = 1'b0;
    end else begin
      if (free_tag_flag) begin
        exp_tag = (mq.size() > 0 && mq[0] == 1) ? 64'd10 : 64'd9;
        check("flag_single", 64'(prev_flag), 64'd0);
        check("flag_after_ack", 64'({prev_req, mem_bus.mem_req}), 64'd2);
        check("flag_queue_nonempty", 64'(mq.size() != 0), 64'd1);
        check("free_tag", 64'(free_this_tag), exp_tag);
      end else begin
        check("idle_tag", 64'(free_this_tag), 64'd0);
      end
      if (mem_bus.mem_req && !prev_req) begin
        check("req_needs_cand", 64'(prev_cand), 64'd1);
        check("req_addr", mem_bus.mem_addr, prev_head_addr);
        check("req_data", mem_bus.mem_wdata, prev_head_data);
      end
      if (mem_bus.mem_req && prev_req) begin
        check("hold_addr", mem_bus.mem_addr, prev_mem_addr);
        check("hold_data", mem_bus.mem_wdata, prev_mem_wdata);
      end
      if (prev_cand && !prev_busy) check("req_issue", 64'(mem_bus.mem_req), 64'd1);
      if (mem_bus.mem_req || free_tag_flag) check("busy_active", 64'(busy), 64'd1);

      h = (mq.size() > 0) ? int'(mq[0]) : 0;
      cand_now = (mq.size() > 0) && rs_ready_bus[1-h] && ok_m[h];
      prev_head_addr = (h == 0) ? rs_st_addr[63:0] : rs_st_addr[127:64];
      prev_head_data = (h == 0) ? rs_st_data[63:0] : rs_st_data[127:64];
      ok_m = ok_m | addr_done;
      if (free_tag_flag) begin
        ok_m[h] = 1'b0;
        if (mq.size() > 0) void'(mq.pop_front());
      end
      if (alloc_valid && (alloc_tag == 4'd9 || alloc_tag == 4'd10) && mq.size() < 2)
        mq.push_back((alloc_tag == 4'd10) ? 1 : 0);
      prev_req = mem_bus.mem_req;
      prev_flag = free_tag_flag;
      prev_cand = cand_now;
      prev_busy = busy;
      prev_mem_addr = mem_bus.mem_addr;
      prev_mem_wdata = mem_bus.mem_wdata;
    end
  end

  initial begin
    #100000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    mem_bus.mem_ack = 1'b0;
    #2;
    check("reset_req", 64'(mem_bus.mem_req), 64'd0);
    check("reset_addr", mem_bus.mem_addr, 64'd0);
    check("reset_data", mem_bus.mem_wdata, 64'd0);
    check("reset_busy", 64'(busy), 64'd0);
    repeat (2) tick();
    rst_n = 1'b1;
    tick();

    // 1: single store, exact latencies
    set_entry(0, 64'h100, 64'hAB);
    alloc_valid = 1'b1; alloc_tag = 4'd9; rs_ready_bus = 2'b10; addr_done = 2'b01;
    tick();
    alloc_valid = 1'b0; addr_done = 2'b00;
    check("t1_no_req_yet", 64'(mem_bus.mem_req), 64'd0);
    tick();
    check("t1_req", 64'(mem_bus.mem_req), 64'd1);
    check("t1_addr", mem_bus.mem_addr, 64'h100);
    check("t1_data", mem_bus.mem_wdata, 64'hAB);
    tick();
    check("t1_req_hold", 64'(mem_bus.mem_req), 64'd1);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    check("t1_flag", 64'(free_tag_flag), 64'd1);
    check("t1_tag", 64'(free_this_tag), 64'd9);
    check("t1_req_drop", 64'(mem_bus.mem_req), 64'd0);
    tick();
    check("t1_flag_end", 64'(free_tag_flag), 64'd0);
    check("t1_busy_end", 64'(busy), 64'd0);

    // 2: allocation order 10 then 9
    set_entry(0, 64'h200, 64'h11);
    set_entry(1, 64'h300, 64'h22);
    alloc_valid = 1'b1; alloc_tag = 4'd10;
    tick();
    alloc_tag = 4'd9; rs_ready_bus = 2'b11; addr_done = 2'b11;
    tick();
    alloc_valid = 1'b0; addr_done = 2'b00;
    commit("t2a", 4'd10, 64'h300, 64'h22, 1);
    commit("t2b", 4'd9, 64'h200, 64'h11, 0);

    // 3: head not ready blocks a ready younger store
    set_entry(0, 64'h500, 64'h66);
    set_entry(1, 64'h600, 64'h77);
    rs_ready_bus = 2'b00;
    alloc_valid = 1'b1; alloc_tag = 4'd9;
    tick();
    alloc_tag = 4'd10; rs_ready_bus = 2'b01; addr_done = 2'b10;
    tick();
    alloc_valid = 1'b0; addr_done = 2'b00;
    repeat (6) begin
      tick();
      check("t3_blocked", 64'(mem_bus.mem_req), 64'd0);
    end
    rs_ready_bus = 2'b11; addr_done = 2'b01;
    tick();
    addr_done = 2'b00;
    commit("t3a", 4'd9, 64'h500, 64'h66, 0);
    commit("t3b", 4'd10, 64'h600, 64'h77, 2);

    // 4: long ack with RS data churning underneath
    set_entry(0, 64'h400, 64'h55);
    rs_ready_bus = 2'b10;
    alloc_valid = 1'b1; alloc_tag = 4'd9; addr_done = 2'b01;
    tick();
    alloc_valid = 1'b0; addr_done = 2'b00;
    wait_req("t4");
    for (int i = 0; i < 5; i++) begin
      rs_st_data[63:0] = 64'(i) * 64'h1111 + 64'h1;
      tick();
      check("t4_req", 64'(mem_bus.mem_req), 64'd1);
      check("t4_addr", mem_bus.mem_addr, 64'h400);
      check("t4_data", mem_bus.mem_wdata, 64'h55);
    end
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    check("t4_tag", 64'(free_this_tag), 64'd9);
    tick();

    // 5: reset while a write is outstanding
    set_entry(1, 64'h700, 64'h88);
    rs_ready_bus = 2'b01;
    alloc_valid = 1'b1; alloc_tag = 4'd10; addr_done = 2'b10;
    tick();
    alloc_valid = 1'b0; addr_done = 2'b00;
    wait_req("t5");
    #2;
    rst_n = 1'b0;
    #1;
    check("t5_async_req", 64'(mem_bus.mem_req), 64'd0);
    check("t5_no_flag", 64'(free_tag_flag), 64'd0);
    check("t5_busy", 64'(busy), 64'd0);
    rs_ready_bus = 2'b00;
    repeat (2) @(posedge clk);
    #1;
    rst_n = 1'b1;
    tick();
    check("t5_busy_after", 64'(busy), 64'd0);
    rs_ready_bus = 2'b11; addr_done = 2'b11;
    tick();
    addr_done = 2'b00;
    repeat (4) begin
      tick();
      check("t5_queue_empty", 64'(mem_bus.mem_req), 64'd0);
    end

    // 6: push during release of the other entry
    do_reset();
    set_entry(1, 64'h800, 64'h99);
    set_entry(0, 64'h900, 64'hAA);
    rs_ready_bus = 2'b01;
    alloc_valid = 1'b1; alloc_tag = 4'd10; addr_done = 2'b10;
    tick();
    alloc_valid = 1'b0; addr_done = 2'b00;
    wait_req("t6");
    check("t6_addr", mem_bus.mem_addr, 64'h800);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    check("t6_rel_tag", 64'(free_this_tag), 64'd10);
    alloc_valid = 1'b1; alloc_tag = 4'd9; rs_ready_bus = 2'b11; addr_done = 2'b01;
    tick();
    alloc_valid = 1'b0; addr_done = 2'b00;
    check("t6_idle_gap", 64'(mem_bus.mem_req), 64'd0);
    tick();
    check("t6_req", 64'(mem_bus.mem_req), 64'd1);
    check("t6_addr2", mem_bus.mem_addr, 64'h900);
    check("t6_data2", mem_bus.mem_wdata, 64'hAA);
    mem_bus.mem_ack = 1'b1;
    tick();
    mem_bus.mem_ack = 1'b0;
    check("t6_tag2", 64'(free_this_tag), 64'd9);
    tick();
    check("t6_busy_end", 64'(busy), 64'd0);
    repeat (2) tick();

    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

endmodule
